// File: rtl/johnson_gray_counter_if.sv
// Bus bundle for johnson_gray_counter: count/load controls toward the counter,
// registered Johnson/index/Gray state and status pulses back.
interface johnson_gray_counter_if #(
  parameter int JW = 4,
  parameter int GW = $clog2(2 * JW)
);
  logic          en;
  logic          dir;
  logic          load;
  logic [GW-1:0] load_idx;
  logic [JW-1:0] j_out;
  logic [GW-1:0] idx;
  logic [GW-1:0] g_out;
  logic          wrap;
  logic          load_err;

  modport master (
    output en, dir, load, load_idx,
    input  j_out, idx, g_out, wrap, load_err
  );

  modport slave (
    input  en, dir, load, load_idx,
    output j_out, idx, g_out, wrap, load_err
  );
endinterface

// File: rtl/johnson_gray_counter.sv
// Up/down Johnson counter with loadable sequence index; the Johnson state, its
// binary index and the Gray code of that index are registered together.
module johnson_gray_counter #(
  parameter int JW = 4,
  parameter int GW = $clog2(2 * JW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  johnson_gray_counter_if.slave bus
);

  if (JW < 2 || JW > 16) begin : g_bad_jw
    $error("johnson_gray_counter: JW must be in 2..16");
  end
  if (GW != $clog2(2 * JW)) begin : g_bad_gw
    $error("johnson_gray_counter: GW is derived from JW and must not be overridden");
  end

  localparam int            SEQ_LEN_I = 2 * JW;
  localparam logic [GW:0]   SEQ_LEN   = (GW + 1)'(SEQ_LEN_I);
  localparam logic [GW-1:0] IDX_MAX   = GW'(SEQ_LEN_I - 1);

  // First half of the sequence fills ones from the bottom, second half clears
  // them from the bottom, so the MSB tells which half a state sits in.
  function automatic logic [GW-1:0] idx_of(input logic [JW-1:0] j);
    logic [GW:0] pc;
    pc = '0;
    for (int b = 0; b < JW; b++) pc += (GW + 1)'(j[b]);
    if (j[JW-1]) return GW'(SEQ_LEN - pc);
    else         return GW'(pc);
  endfunction

  function automatic logic [JW-1:0] j_of_idx(input logic [GW-1:0] i);
    logic [JW-1:0] j;
    int            iv;
    iv = int'(i);
    j  = '0;
    for (int b = 0; b < JW; b++) begin
      if (iv < JW) j[b] = (b < iv);
      else         j[b] = (b >= iv - JW);
    end
    return j;
  endfunction

  logic [JW-1:0] j_q, j_nx;
  logic [GW-1:0] idx_q, idx_nx;
  logic [GW-1:0] g_q, g_nx;
  logic          wrap_q, wrap_nx;
  logic          err_q, err_nx;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    j_nx    = j_q;
    wrap_nx = 1'b0;
    err_nx  = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.load_idx} < SEQ_LEN) j_nx   = j_of_idx(bus.load_idx);
      else                                err_nx = 1'b1;
    end else if (bus.en) begin
      if (bus.dir) begin
        j_nx    = {j_q[JW-2:0], ~j_q[JW-1]};
        wrap_nx = (idx_q == IDX_MAX);
      end else begin
        j_nx    = {~j_q[0], j_q[JW-1:1]};
        wrap_nx = (idx_q == '0);
      end
    end
    idx_nx = idx_of(j_nx);
    g_nx   = idx_nx ^ (idx_nx >> 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      j_q    <= '0;
      idx_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      j_q    <= j_nx;
      idx_q  <= idx_nx;
      g_q    <= g_nx;
      wrap_q <= wrap_nx;
      err_q  <= err_nx;
    end
  end

  assign bus.j_out    = j_q;
  assign bus.idx      = idx_q;
  assign bus.g_out    = g_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_johnson_gray_counter.sv
// Directed-vector bench for johnson_gray_counter at JW=4 and JW=3 with
// hand-computed expected Johnson, index, Gray and pulse values.
module tb_johnson_gray_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  johnson_gray_counter_if #(.JW(4)) bus4 ();
  johnson_gray_counter_if #(.JW(3)) bus3 ();

  johnson_gray_counter #(.JW(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  johnson_gray_counter #(.JW(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] j, input logic [2:0] i,
                      input logic [2:0] g, input logic w, input logic e);
    check({tag, ".j"},    32'(bus4.j_out),    32'(j));
    check({tag, ".idx"},  32'(bus4.idx),      32'(i));
    check({tag, ".g"},    32'(bus4.g_out),    32'(g));
    check({tag, ".wrap"}, 32'(bus4.wrap),     32'(w));
    check({tag, ".err"},  32'(bus4.load_err), 32'(e));
  endtask

  task automatic chk3(input string tag, input logic [2:0] j, input logic [2:0] i,
                      input logic [2:0] g, input logic w, input logic e);
    check({tag, ".j"},    32'(bus3.j_out),    32'(j));
    check({tag, ".idx"},  32'(bus3.idx),      32'(i));
    check({tag, ".g"},    32'(bus3.g_out),    32'(g));
    check({tag, ".wrap"}, 32'(bus3.wrap),     32'(w));
    check({tag, ".err"},  32'(bus3.load_err), 32'(e));
  endtask

  // JW=4 up sweep from index 0
  logic [3:0] up4_j [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                            4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [2:0] up4_i [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] up4_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                            3'b111, 3'b101, 3'b100, 3'b000};
  // JW=3 up sweep from index 0
  logic [2:0] up3_j [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
  logic [2:0] up3_i [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
  logic [2:0] up3_g [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b000};

  initial begin
    rst_n = 1'b0;
    bus4.en = 1'b0; bus4.dir = 1'b1; bus4.load = 1'b0; bus4.load_idx = '0;
    bus3.en = 1'b0; bus3.dir = 1'b1; bus3.load = 1'b0; bus3.load_idx = '0;
    tick();
    tick();
    chk4("rst4", 4'b0000, 3'd0, 3'b000, 1'b0, 1'b0);
    chk3("rst3", 3'b000, 3'd0, 3'b000, 1'b0, 1'b0);

    // Up count through a full lap; wrap only on the return to 0000
    rst_n = 1'b1; bus4.en = 1'b1; bus4.dir = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk4($sformatf("up4_%0d", k), up4_j[k], up4_i[k], up4_g[k], (k == 7), 1'b0);
    end

    // Down from reset wraps to the last index
    rst_n = 1'b0; bus4.en = 1'b0;
    tick();
    rst_n = 1'b1; bus4.en = 1'b1; bus4.dir = 1'b0;
    tick();
    chk4("dn4_0", 4'b1000, 3'd7, 3'b100, 1'b1, 1'b0);
    tick();
    chk4("dn4_1", 4'b1100, 3'd6, 3'b101, 1'b0, 1'b0);

    // Load index 5 overrides en, then hold for 3 cycles
    bus4.load = 1'b1; bus4.load_idx = 3'd5; bus4.en = 1'b1; bus4.dir = 1'b1;
    tick();
    chk4("ld5", 4'b1110, 3'd5, 3'b111, 1'b0, 1'b0);
    bus4.load = 1'b0; bus4.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk4($sformatf("hold%0d", k), 4'b1110, 3'd5, 3'b111, 1'b0, 1'b0);
    end

    // Loading index 0 from index 7 never signals wrap
    bus4.load = 1'b1; bus4.load_idx = 3'd7;
    tick();
    chk4("ld7", 4'b1000, 3'd7, 3'b100, 1'b0, 1'b0);
    bus4.load_idx = 3'd0; bus4.en = 1'b1; bus4.dir = 1'b1;
    tick();
    chk4("ld0", 4'b0000, 3'd0, 3'b000, 1'b0, 1'b0);

    // Direction changes on consecutive edges, ending in a down wrap
    bus4.load = 1'b0; bus4.en = 1'b1; bus4.dir = 1'b1;
    tick();
    chk4("dir_up", 4'b0001, 3'd1, 3'b001, 1'b0, 1'b0);
    bus4.dir = 1'b0;
    tick();
    chk4("dir_dn", 4'b0000, 3'd0, 3'b000, 1'b0, 1'b0);
    tick();
    chk4("dir_wr", 4'b1000, 3'd7, 3'b100, 1'b1, 1'b0);

    // Reset beats load and en mid-sequence; counting restarts from 0
    bus4.en = 1'b0; bus4.load = 1'b1; bus4.load_idx = 3'd6;
    tick();
    chk4("ld6", 4'b1100, 3'd6, 3'b101, 1'b0, 1'b0);
    rst_n = 1'b0; bus4.load_idx = 3'd3; bus4.en = 1'b1;
    tick();
    chk4("rst_mid", 4'b0000, 3'd0, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1; bus4.load = 1'b0; bus4.en = 1'b1; bus4.dir = 1'b1;
    tick();
    chk4("rst_resume", 4'b0001, 3'd1, 3'b001, 1'b0, 1'b0);
    bus4.en = 1'b0;

    // JW=3: full up lap starting from index 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; bus3.en = 1'b1; bus3.dir = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk3($sformatf("up3_%0d", k), up3_j[k], up3_i[k], up3_g[k], (k == 5), 1'b0);
    end

    // JW=3: illegal loads hold state and pulse load_err, even with en high
    bus3.en = 1'b0; bus3.load = 1'b1; bus3.load_idx = 3'd2;
    tick();
    chk3("ld3_2", 3'b011, 3'd2, 3'b011, 1'b0, 1'b0);
    bus3.load_idx = 3'd6;
    tick();
    chk3("bad6", 3'b011, 3'd2, 3'b011, 1'b0, 1'b1);
    bus3.load_idx = 3'd5;
    tick();
    chk3("ld3_5", 3'b100, 3'd5, 3'b111, 1'b0, 1'b0);
    bus3.load_idx = 3'd7; bus3.en = 1'b1;
    tick();
    chk3("bad7", 3'b100, 3'd5, 3'b111, 1'b0, 1'b1);
    bus3.load = 1'b0; bus3.en = 1'b0;
    tick();
    chk3("err_clr", 3'b100, 3'd5, 3'b111, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
